// File: rtl/hub75_shifter.sv
// HUB75 column shifter: fetches one framebuffer row, extracts a bit-plane and shifts
// it onto the panel RGB lines with a generated shift clock, then pulses LAT.
module hub75_shifter #(
    parameter int hpixel_p    = 64,
    parameter int vpixel_p    = 64,
    parameter int bpp_p       = 8,
    parameter int segments_p  = 2,
    parameter int clk_div_p   = 2,
    parameter int latch_len_p = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             i_en,
    input  logic                                             i_start,
    input  logic [$clog2(vpixel_p/segments_p)-1:0]           i_row,
    input  logic [$clog2(bpp_p)-1:0]                         i_pix_bit,
    input  logic                                             i_latch_go,
    output logic                                             o_rd_en,
    output logic [$clog2((vpixel_p/segments_p)*hpixel_p)-1:0] o_rd_addr,
    input  logic [segments_p*3*bpp_p-1:0]                    i_rd_data,
    output logic [segments_p*3-1:0]                          o_rgb,
    output logic                                             o_sclk,
    output logic                                             o_latch,
    output logic                                             o_busy,
    output logic                                             o_done
);
    localparam int out_rows_lp = vpixel_p / segments_p;
    localparam int row_w_lp    = $clog2(out_rows_lp);
    localparam int bit_w_lp    = $clog2(bpp_p);
    localparam int col_w_lp    = $clog2(hpixel_p);
    localparam int addr_w_lp   = $clog2(out_rows_lp * hpixel_p);
    localparam int cnt_max_lp  = (clk_div_p > latch_len_p) ? clk_div_p : latch_len_p;
    localparam int cnt_w_lp    = (cnt_max_lp > 1) ? $clog2(cnt_max_lp) : 1;
    localparam int lanes_lp    = segments_p * 3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPTURE, S_LOW, S_HIGH, S_WAIT_LAT, S_LATCH
    } state_t;

    state_t                r_state;
    logic [row_w_lp-1:0]   r_row;
    logic [bit_w_lp-1:0]   r_bit;
    logic [col_w_lp-1:0]   r_col;
    logic [cnt_w_lp-1:0]   r_cnt;
    logic                  r_rd_en;
    logic [addr_w_lp-1:0]  r_rd_addr;
    logic [lanes_lp-1:0]   r_rgb;
    logic                  r_sclk;
    logic                  r_latch;
    logic                  r_busy;
    logic                  r_done;
    logic [lanes_lp-1:0]   w_rgb;

    function automatic logic [addr_w_lp-1:0] addr_of(input logic [row_w_lp-1:0] row,
                                                     input logic [col_w_lp-1:0] col);
        return addr_w_lp'(row) * addr_w_lp'(hpixel_p) + addr_w_lp'(col);
    endfunction

    // Pick the latched bit-plane out of every colour channel of every segment.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_rgb unassigned (no latch).
        w_rgb = '0;
        for (int i = 0; i < lanes_lp; i++) begin
            w_rgb[i] = i_rd_data[i*bpp_p + int'(r_bit)];
        end
    end

    // NOTE: all state and registered outputs update with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_bit     <= '0;
            r_col     <= '0;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_rgb     <= '0;
            r_sclk    <= 1'b0;
            r_latch   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (!i_en) begin
            // Disable abandons the load silently: no LAT, no done.
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_rgb     <= '0;
            r_sclk    <= 1'b0;
            r_latch   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The done cycle itself does not accept a new request.
                    if (i_start && !r_done) begin
                        r_row     <= i_row;
                        r_bit     <= i_pix_bit;
                        r_col     <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= addr_of(i_row, '0);
                        r_busy    <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_rgb   <= w_rgb;
                    r_cnt   <= '0;
                    r_state <= S_LOW;
                end
                S_LOW: begin
                    if (r_cnt == cnt_w_lp'(clk_div_p - 1)) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + cnt_w_lp'(1);
                    end
                end
                S_HIGH: begin
                    if (r_cnt == cnt_w_lp'(clk_div_p - 1)) begin
                        r_cnt  <= '0;
                        r_sclk <= 1'b0;
                        if (r_col == col_w_lp'(hpixel_p - 1)) begin
                            r_state <= S_WAIT_LAT;
                        end else begin
                            r_col     <= r_col + col_w_lp'(1);
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= addr_of(r_row, r_col + col_w_lp'(1));
                            r_state   <= S_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt + cnt_w_lp'(1);
                    end
                end
                S_WAIT_LAT: begin
                    if (i_latch_go) begin
                        r_latch <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == cnt_w_lp'(latch_len_p - 1)) begin
                        r_latch <= 1'b0;
                        r_rgb   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + cnt_w_lp'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_addr;
    assign o_rgb     = r_rgb;
    assign o_sclk    = r_sclk;
    assign o_latch   = r_latch;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
endmodule

// File: tb/tb_hub75_shifter.sv
// Directed bench for hub75_shifter: default build plus a clk_div_p=1 / latch_len_p=3 build.
module tb_hub75_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b1, i_start = 1'b0, i_latch_go = 1'b1;
    logic [4:0]  i_row = '0;
    logic [2:0]  i_pix_bit = '0;
    logic        o_rd_en, o_sclk, o_latch, o_busy, o_done;
    logic [10:0] o_rd_addr;
    logic [47:0] rd_data = '0;
    logic [5:0]  o_rgb;

    logic        s2_start = 1'b0;
    logic [4:0]  s2_row = '0;
    logic [2:0]  s2_bit = '0;
    logic        s2_rd_en, s2_sclk, s2_latch, s2_busy, s2_done;
    logic [10:0] s2_rd_addr;
    logic [47:0] s2_rd_data = '0;
    logic [5:0]  s2_rgb;

    int checks = 0;
    int errors = 0;
    int mem_mode = 0;

    always #5 clk = ~clk;

    hub75_shifter u_dut (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_start(i_start), .i_row(i_row),
        .i_pix_bit(i_pix_bit), .i_latch_go(i_latch_go), .o_rd_en(o_rd_en),
        .o_rd_addr(o_rd_addr), .i_rd_data(rd_data), .o_rgb(o_rgb), .o_sclk(o_sclk),
        .o_latch(o_latch), .o_busy(o_busy), .o_done(o_done)
    );

    hub75_shifter #(.clk_div_p(1), .latch_len_p(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_start(s2_start), .i_row(s2_row),
        .i_pix_bit(s2_bit), .i_latch_go(1'b1), .o_rd_en(s2_rd_en),
        .o_rd_addr(s2_rd_addr), .i_rd_data(s2_rd_data), .o_rgb(s2_rgb), .o_sclk(s2_sclk),
        .o_latch(s2_latch), .o_busy(s2_busy), .o_done(s2_done)
    );

    // Framebuffer word depends only on the column; mode 1 gives every channel distinct bits.
    function automatic logic [47:0] mk_word(input int addr, input int mode);
        logic [7:0] c8;
        c8 = 8'(addr % 64);
        if (mode == 0) return {6{c8}};
        return {8'hF0, c8 << 2, 8'h0F, 8'hA5, ~c8, c8};
    endfunction

    function automatic logic [5:0] exp_rgb(input int col, input int b, input int mode);
        logic [47:0] w;
        logic [5:0]  e;
        w = mk_word(col, mode);
        for (int ch = 0; ch < 6; ch++) e[ch] = w[ch*8 + b];
        return e;
    endfunction

    always @(posedge clk) begin
        if (o_rd_en) rd_data <= mk_word(int'(o_rd_addr), mem_mode);
        if (s2_rd_en) s2_rd_data <= mk_word(int'(s2_rd_addr), 0);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check(tag, longint'({o_rd_en, o_rd_addr, o_rgb, o_sclk, o_latch, o_busy, o_done}), 0);
    endtask

    // Issue one request and follow it to o_done; returns at the negedge of the done cycle.
    task automatic run_row(input string tag, input int row, input int bitp, input int mode,
                           input int go_delay, input bit disturb);
        int cyc, naddr, bad_addr, first_addr, last_addr, nedge, bad_rgb;
        int first_edge, last_edge, lat, done_cyc, busy_bad, wait_bad;
        logic prev_sclk;
        logic [5:0] hold_rgb;
        mem_mode = mode;
        @(negedge clk);
        i_row = 5'(row); i_pix_bit = 3'(bitp); i_start = 1'b1; i_latch_go = (go_delay == 0);
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1; naddr = 0; bad_addr = 0; first_addr = -1; last_addr = -1; nedge = 0;
        bad_rgb = 0; first_edge = -1; last_edge = -1; lat = 0; done_cyc = -1;
        busy_bad = 0; wait_bad = 0; prev_sclk = 1'b0; hold_rgb = '0;
        forever begin
            if (go_delay > 0 && cyc == 385 + go_delay) i_latch_go = 1'b1;
            if (disturb && cyc == 100) begin
                i_start = 1'b1; i_pix_bit = 3'(bitp ^ 5); i_row = 5'(row ^ 1);
            end
            if (disturb && cyc == 101) i_start = 1'b0;
            if (o_rd_en) begin
                if (int'(o_rd_addr) != row*64 + naddr) bad_addr++;
                if (naddr == 0) first_addr = int'(o_rd_addr);
                last_addr = int'(o_rd_addr);
                naddr++;
            end
            if (o_sclk && !prev_sclk) begin
                if (o_rgb !== exp_rgb(nedge, bitp, mode)) bad_rgb++;
                if (nedge == 0) first_edge = cyc;
                last_edge = cyc;
                nedge++;
            end
            prev_sclk = o_sclk;
            if (o_latch) lat++;
            if (cyc == 385) hold_rgb = o_rgb;
            if (go_delay > 0 && cyc >= 385 && cyc <= 385 + go_delay)
                if (!o_busy || o_sclk || o_latch || o_rgb !== hold_rgb) wait_bad++;
            if (o_done) begin
                if (o_busy) busy_bad++;
                done_cyc = cyc;
                break;
            end
            if (!o_busy) busy_bad++;
            if (cyc >= 1200) break;
            @(negedge clk);
            cyc++;
        end
        i_latch_go = 1'b1;
        check({tag, " addr_count"}, naddr, 64);
        check({tag, " addr_seq"}, bad_addr, 0);
        check({tag, " first_addr"}, first_addr, row*64);
        check({tag, " last_addr"}, last_addr, row*64 + 63);
        check({tag, " sclk_edges"}, nedge, 64);
        check({tag, " rgb_at_edges"}, bad_rgb, 0);
        check({tag, " first_edge_cyc"}, first_edge, 5);
        check({tag, " last_edge_cyc"}, last_edge, 383);
        check({tag, " latch_cycles"}, lat, 1);
        check({tag, " done_cyc"}, done_cyc, 387 + go_delay);
        check({tag, " busy_profile"}, busy_bad, 0);
        if (go_delay > 0) check({tag, " wait_hold"}, wait_bad, 0);
        if (done_cyc > 0) check({tag, " rgb_cleared"}, longint'(o_rgb), 0);
    endtask

    // Start a request, stop it at column 10 by disable or by reset, then confirm a quiet idle.
    task automatic abort_row(input string tag, input bit use_reset);
        int seen_done;
        @(negedge clk);
        i_row = 5'd3; i_pix_bit = 3'd1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (60) @(negedge clk);
        check({tag, " col10_fetch"}, longint'({o_rd_en, o_rd_addr}), longint'({1'b1, 11'd202}));
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            check_idle_zero({tag, " zero_immediate"});
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            i_en = 1'b0;
            @(negedge clk);
            check_idle_zero({tag, " zero_next"});
            i_en = 1'b1;
        end
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done || o_busy || o_latch || o_sclk) seen_done++;
        end
        check({tag, " stays_idle"}, seen_done, 0);
    endtask

    initial begin
        int cyc, nedge, first_edge, last_edge, lat, done_cyc, first_addr;
        logic prev_sclk;
        #12;
        check_idle_zero("reset_outputs");
        check("reset_outputs_b", longint'({s2_rd_en, s2_rgb, s2_sclk, s2_latch, s2_busy, s2_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_row("row5_bit0", 5, 0, 0, 0, 1'b0);
        run_row("row31_bit7", 31, 7, 0, 0, 1'b0);
        run_row("latch_wait", 2, 5, 1, 50, 1'b0);
        run_row("disturb", 12, 3, 1, 0, 1'b1);

        // Start raised in the done cycle is ignored; held one cycle longer it is accepted.
        i_start = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", o_busy, 0);
        @(negedge clk);
        i_start = 1'b0;
        check("start_after_done_taken", o_busy, 1);
        cyc = 0;
        while (!o_done && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_completes", cyc, 386);

        abort_row("en_drop", 1'b0);
        run_row("after_en_drop", 5, 0, 0, 0, 1'b0);
        abort_row("rst_drop", 1'b1);
        run_row("after_reset", 7, 2, 1, 0, 1'b0);

        // Fast build: 4 cycles per column, 3-cycle LAT.
        mem_mode = 0;
        @(negedge clk);
        s2_row = 5'd9; s2_bit = 3'd1; s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        cyc = 1; nedge = 0; first_edge = -1; last_edge = -1; lat = 0; done_cyc = -1;
        first_addr = -1; prev_sclk = 1'b0;
        forever begin
            if (s2_rd_en && first_addr < 0) first_addr = int'(s2_rd_addr);
            if (s2_sclk && !prev_sclk) begin
                if (nedge == 0) first_edge = cyc;
                if (nedge == 63) check("fast_rgb_col63", longint'(s2_rgb), 63);
                if (nedge == 2) check("fast_rgb_col2", longint'(s2_rgb), 63);
                if (nedge == 5) check("fast_rgb_col5", longint'(s2_rgb), 0);
                last_edge = cyc;
                nedge++;
            end
            prev_sclk = s2_sclk;
            if (s2_latch) lat++;
            if (s2_done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc >= 1000) break;
            @(negedge clk);
            cyc++;
        end
        check("fast_first_addr", first_addr, 576);
        check("fast_sclk_edges", nedge, 64);
        check("fast_first_edge", first_edge, 4);
        check("fast_last_edge", last_edge, 256);
        check("fast_latch_cycles", lat, 3);
        check("fast_done_cyc", done_cyc, 261);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hub75_shifter.md
Name: hub75_shifter

Overview:
- Upstream column-shift stage of the HUB75 driver.
- Per request, reads one row of pixels from the framebuffer and extracts one bit-plane. It shifts that data serially onto the panel RGB lines with a generated shift clock, then pulses LAT when the row/bit timer grants the blanking window.
- Runs concurrently with the timer's display interval, so the next bit-plane is loaded while the current one is lit.

Parameters:
- hpixel_p, 64, columns per panel row (≥2).
- vpixel_p, 64, panel rows.
- bpp_p, 8, bits per colour channel.
- segments_p, 2, vertically split segments driven in parallel; out_rows_p = vpixel_p/segments_p.
- clk_div_p, 2, system cycles per shift-clock half period (≥1).
- latch_len_p, 1, LAT pulse width in system cycles (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  block enable; low forces IDLE
- i_start  in  1  load request, sampled in IDLE only
- i_row  in  $clog2(out_rows_p)  row within segment to load
- i_pix_bit  in  $clog2(bpp_p)  bit-plane index to load
- i_latch_go  in  1  latch permission (blanking window open)
- o_rd_en  out  1  framebuffer read strobe
- o_rd_addr  out  $clog2(out_rows_p*hpixel_p)  read address = row*hpixel_p + col
- i_rd_data  in  segments_p*3*bpp_p  read data, valid exactly 1 cycle after o_rd_en
- o_rgb  out  segments_p*3  panel data, bit s*3+c (c: 0=R, 1=G, 2=B)
- o_sclk  out  1  panel shift clock; panel samples on rising edge
- o_latch  out  1  panel LAT
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after LAT completes

Behaviour:
- Reset: state IDLE, col=0; all outputs 0 (o_rgb, o_sclk, o_latch, o_rd_en, o_rd_addr, o_busy, o_done).
- IDLE: on i_start && i_en, capture i_row and i_pix_bit into internal registers, clear col, go to FETCH. i_start is ignored outside IDLE.
- FETCH (1 cycle): o_rd_en=1, o_rd_addr=row*hpixel_p+col. o_rd_en is 0 in all other states.
- CAPTURE (1 cycle): o_rgb[s*3+c] <= i_rd_data[(s*3+c)*bpp_p + pix_bit]. o_sclk=0.
- LOW (clk_div_p cycles): o_sclk=0, o_rgb held.
- HIGH (clk_div_p cycles): o_sclk=1, o_rgb held.
  - At the end of HIGH: if col==hpixel_p-1, go to WAIT_LAT; else col++ and go to FETCH.
- Column timing: each column costs 2+2*clk_div_p cycles. Defaults: 6 cycles/column, 384 cycles/row. Exactly hpixel_p rising edges of o_sclk occur per request.
- WAIT_LAT: o_sclk=0, o_rgb held. Each cycle i_latch_go=1 moves the block to LATCH next cycle, including the entry cycle if it is already high.
- LATCH (latch_len_p cycles): o_latch=1. On exit: o_rgb<=0, o_done=1 for one cycle, state IDLE.
  - o_busy drops in that same cycle.
  - i_start is accepted from the following cycle.
- o_done never coincides with o_busy=1.
- i_en low in any state: next edge goes to IDLE with outputs zeroed and no o_done. Any load in progress is discarded.
- Async reset mid-operation: same as reset; no partial LAT pulse is extended.
- Address arithmetic is unsigned, width $clog2(out_rows_p*hpixel_p); max address out_rows_p*hpixel_p-1 with no wrap.
- The bit-plane index is held constant for the whole request, even if i_pix_bit changes mid-shift.
- i_latch_go in any state other than WAIT_LAT has no effect.

Test Plan:
- Defaults, framebuffer word(row 5, col c) = {R=G=B=c} for both segments, start row=5 bit=0, i_latch_go held high. Expected:
  - rd_addr runs 320..383.
  - 64 sclk rising edges.
  - o_rgb at edge k = 6'b111111 for odd k, 0 for even k.
  - o_latch high 1 cycle, then o_done at cycle 387 after start.
- Same data, bit=7, row=31. Expected: addresses 1984..2047, all o_rgb samples 0 (values <64), and address width/last address correct.
- i_latch_go held low for 50 cycles after the last column. Expected: block holds WAIT_LAT with o_busy=1, o_sclk=0, o_rgb stable; it latches the cycle after i_latch_go rises.
- i_start pulsed while busy, and i_pix_bit changed mid-row. Expected: no restart; row and bit-plane unchanged; the next start is accepted the cycle after o_done.
- i_en dropped at column 10, and separately rst_n asserted at column 10. Expected: next cycle (immediate for reset) all outputs 0, IDLE, no o_done; a fresh start then runs a full 64 columns.
- clk_div_p=1, latch_len_p=3 build. Expected: 4 cycles/column, 256-cycle row, o_latch high exactly 3 cycles.
